// File: rtl/rr_arbiter8_if.sv
// Request/grant bundle between eight requesters and the round-robin arbiter.
interface rr_arbiter8_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_idx;
   logic       gnt_valid;
   logic       hold_expire;

   modport master (output req, input gnt, gnt_idx, gnt_valid, hold_expire);
   modport slave  (input req, output gnt, gnt_idx, gnt_valid, hold_expire);
endinterface

// File: rtl/rr_arbiter8.sv
// 8-way round-robin arbiter with registered winner index, hold-while-requesting
// grants and an optional hold limit that forces rotation when others wait.
module rr_arbiter8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 8
) (
   input  logic         clk,
   input  logic         rst_n,
   rr_arbiter8_if.slave bus
);

   typedef enum logic {IDLE, GRANT} state_t;

   localparam int             LIM_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
   localparam logic [CNT_W-1:0] LIM = CNT_W'(LIM_I);

   state_t           state_q, state_d;
   logic [2:0]       ptr_q, ptr_d;
   logic [2:0]       idx_q, idx_d;
   logic             vld_q, vld_d;
   logic             exp_q, exp_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [2:0]       win;

   // Descending scan so the smallest offset from the pointer wins.
   function automatic logic [2:0] pick(input logic [7:0] r, input logic [2:0] p);
      logic [2:0] j;
      pick = p;
      for (int i = 7; i >= 0; i--) begin
         j = p + 3'(i);
         if (r[j]) pick = j;
      end
   endfunction

   assign win = pick(bus.req, ptr_q);

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      vld_d   = vld_q;
      exp_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            vld_d = 1'b0;
            if (|bus.req) begin
               idx_d   = win;
               ptr_d   = win + 3'd1;
               vld_d   = 1'b1;
               cnt_d   = '0;
               state_d = GRANT;
            end
         end
         GRANT: begin
            if (bus.req[idx_q] && (MAX_HOLD == 0 || cnt_q < LIM)) begin
               if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
            end else if (bus.req[idx_q]) begin
               // Hold limit reached: the holder sits last in the scan order.
               idx_d = win;
               ptr_d = win + 3'd1;
               cnt_d = '0;
               exp_d = 1'b1;
            end else if (|bus.req) begin
               idx_d = win;
               ptr_d = win + 3'd1;
               cnt_d = '0;
            end else begin
               vld_d   = 1'b0;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         vld_q   <= 1'b0;
         exp_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         vld_q   <= vld_d;
         exp_q   <= exp_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.gnt         = vld_q ? (8'b1 << idx_q) : 8'h00;
   assign bus.gnt_idx     = idx_q;
   assign bus.gnt_valid   = vld_q;
   assign bus.hold_expire = exp_q;

endmodule

// File: doc/rr_arbiter8.md
Name: rr_arbiter8

Overview:
- Round-robin arbiter sharing one 8-way resource among 8 requesters.
- Its one-hot grant vector is the 3-to-8 decoded form of a registered 3-bit winner index, so it drives per-requester enables directly.
- Provides a registered grant with hold-while-requesting semantics.
- An optional hold limit prevents one requester from starving the others.

Parameters:
- MAX_HOLD, 16: maximum consecutive cycles one grant is held while others wait. 0 = unlimited. Legal range 0..255.
- CNT_W, 8: hold counter width. Must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req  input  8  request per requester; bit i = requester i.
- gnt  output  8  one-hot grant; equals decode(gnt_idx) when gnt_valid=1, else 8'h00.
- gnt_idx  output  3  index of current grantee.
- gnt_valid  output  1  a grant is active.
- hold_expire  output  1  one-cycle pulse when a grant is revoked by the MAX_HOLD limit.

Behaviour:
- Reset (async assert on rst_n=0, applies immediately, including mid-grant):
  - gnt=8'h00, gnt_idx=0, gnt_valid=0, hold_expire=0.
  - State=IDLE, priority pointer ptr=0, hold_cnt=0.
  - Reset deassertion is synchronous to clk (externally synchronised).
- Arbitration function pick(req, ptr): first set bit scanning ptr, ptr+1, …, 7, 0, …, ptr-1 (mod 8).
- State machine: two states, IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req==0: stay in IDLE, outputs 0.
  - Else: at the next edge, gnt_idx=pick(req,ptr), gnt_valid=1, ptr=gnt_idx+1 (mod 8), hold_cnt=0; go to GRANT.
  - Latency from req high to gnt visible = 1 cycle.
- GRANT, with k=gnt_idx:
  - Continue: if req[k]=1 and (MAX_HOLD==0 or hold_cnt<MAX_HOLD-1), hold the grant and increment hold_cnt. Changes on other req bits are ignored.
  - Release: if req[k]=0, re-arbitrate in the same cycle using pick(req, ptr), where ptr already equals k+1.
    - Any other request pending: new grant at the next edge, giving back-to-back grants with no idle cycle. Update ptr and clear hold_cnt.
    - None pending: gnt_valid=0, gnt=0, go to IDLE.
  - Expire: if req[k]=1, MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1, re-arbitrate with pick(req, ptr).
    - k is scanned last, so it is re-granted only when it is the sole requester.
    - hold_expire=1 for exactly the cycle in which the new grant (possibly k again) becomes visible.
    - hold_cnt resets to 0.
  - A grant therefore lasts at most MAX_HOLD cycles while others wait.
- Invariants:
  - popcount(gnt)<=1 at all times.
  - gnt!=0 iff gnt_valid.
  - gnt_idx holds its last value when gnt_valid=0.
- Fairness: any continuously asserted request is granted within 7 grant turns.
- Counter: hold_cnt saturates and never wraps when MAX_HOLD=0.

Test Plan:
- Reset: rst_n=0 asserted mid-grant (gnt=8'h04) -> gnt=0, gnt_valid=0, gnt_idx=0 immediately, without waiting for a clk edge. After release, req=8'h01 -> gnt=8'h01 one cycle later.
- Rotation: req=8'hFF held, MAX_HOLD=1 -> gnt sequence 01,02,04,…,80,01. hold_expire=1 on each transition after the first grant.
- Back-to-back release: grant on requester 2, req=8'h24, then drop bit 2 -> next cycle gnt=8'h20, gnt_idx=5, no idle cycle.
- Wrap-around: ptr=7 (after a grant to 6), req=8'h41 -> grant to 0 before 6.
- Hold limit: MAX_HOLD=4, req=8'h09 held continuously -> gnt=08 for 4 cycles, then 01 with hold_expire pulse.
  - Sole requester req=8'h08: re-granted 08 every 4 cycles with hold_expire pulses.
- Idle return: single req=8'h10 pulsed for 3 cycles -> gnt=8'h10 for 3 cycles starting 1 cycle late, then gnt=0, gnt_valid=0. One-hot invariant checked every cycle with random req.
